// File: rtl/ula_serial_fatias_pkg.sv
// Shared definitions for the slice-serial ALU: opcode encodings, FSM state
// encoding and small opcode classification helpers.
//   OP_ADD..OP_SBB : 3-bit operation codes presented on seletor
//   estado_t       : OCIOSO (idle), CALCULA (computing), PRONTO (result ready)
package ula_serial_fatias_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_ADC = 3'b110;
    localparam logic [2:0] OP_SBB = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    // True for the four adder-based operations.
    function automatic logic eh_aritmetica(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // True when the B operand enters the adder inverted.
    function automatic logic eh_subtracao(input logic [2:0] op);
        case (op)
            OP_SUB, OP_SBB: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // Carry fed into the least significant slice.
    function automatic logic carry_inicial(input logic [2:0] op, input logic cin);
        case (op)
            OP_SUB:         return 1'b1;
            OP_ADC, OP_SBB: return cin;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ula_serial_fatias_fatia.sv
// ula_fatia: combinational SLICE-bit ALU slice.
//   a, b      : operand slices
//   cin       : carry into this slice
//   seletor   : operation code
//   res       : slice result
//   cout      : carry out of this slice (0 for logic operations)
//   gerado    : slice generates a carry regardless of cin
//   propagado : slice propagates cin to cout
module ula_fatia
    import ula_serial_fatias_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [2:0]       seletor,
    output logic [SLICE-1:0] res,
    output logic             cout,
    output logic             gerado,
    output logic             propagado
);

    logic [SLICE-1:0] w_bop;
    logic [SLICE:0]   w_soma;
    logic [SLICE:0]   w_soma_sem_cin;

    // Adder path, with B inverted for the subtracting opcodes.
    always_comb begin
        w_bop          = eh_subtracao(seletor) ? ~b : b;
        w_soma         = {1'b0, a} + {1'b0, w_bop} + {{SLICE{1'b0}}, cin};
        w_soma_sem_cin = {1'b0, a} + {1'b0, w_bop};
    end

    // Result and carry selection per opcode.
    always_comb begin
        res  = {SLICE{1'b0}};
        cout = 1'b0;
        case (seletor)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                res  = w_soma[SLICE-1:0];
                cout = w_soma[SLICE];
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            default: res = {SLICE{1'b0}};
        endcase
    end

    // Group generate/propagate: carry out == gerado | (propagado & cin).
    always_comb begin
        if (eh_aritmetica(seletor)) begin
            gerado    = w_soma_sem_cin[SLICE];
            propagado = &(a ^ w_bop);
        end else begin
            gerado    = 1'b0;
            propagado = 1'b0;
        end
    end

endmodule

// File: rtl/ula_serial_fatias.sv
// ula_serial_fatias: multi-cycle ALU computing a WIDTH-bit operation one
// SLICE-bit slice per clock, LSB slice first, with start/done handshake.
//   clk, rst        : clock and synchronous active-high reset
//   inicio          : start request, accepted whenever not ocupado
//   A, B, carry_in  : operands and carry-in, latched on acceptance
//   seletor         : operation code, latched on acceptance
//   ocupado         : operation in progress
//   pronto          : one-cycle pulse, resultado and flags just updated
//   resultado       : result of the last completed operation
//   carry_out, zero, negativo, overflow : C/Z/N/V flags of that result
module ula_serial_fatias
    import ula_serial_fatias_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic [2:0]       seletor,
    output logic             ocupado,
    output logic             pronto,
    output logic [WIDTH-1:0] resultado,
    output logic             carry_out,
    output logic             zero,
    output logic             negativo,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_ULTIMA = IDX_W'(N - 1);

    if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_param_invalido
        $error("ula_serial_fatias: WIDTH must be a non-zero multiple of SLICE");
    end

    estado_t          r_estado;
    estado_t          w_estado_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_resultado;
    logic             r_carry_out;
    logic             r_zero;
    logic             r_negativo;
    logic             r_overflow;

    logic             w_aceita;
    logic             w_ultima;
    logic [SLICE-1:0] w_res;
    logic             w_cout;
    logic             w_gerado;
    logic             w_propagado;
    logic             w_carry_grupo;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             w_bop_msb;
    logic             w_overflow;

    // Operands are shifted right after each slice, so the active slice is
    // always the low SLICE bits of r_a/r_b.
    ula_fatia #(.SLICE(SLICE)) u_fatia (
        .a         (r_a[SLICE-1:0]),
        .b         (r_b[SLICE-1:0]),
        .cin       (r_carry),
        .seletor   (r_op),
        .res       (w_res),
        .cout      (w_cout),
        .gerado    (w_gerado),
        .propagado (w_propagado)
    );

    // Handshake qualification and slice bookkeeping.
    always_comb begin
        w_aceita      = inicio && (r_estado != CALCULA);
        w_ultima      = (r_estado == CALCULA) && (r_idx == IDX_ULTIMA);
        w_carry_grupo = w_gerado | (w_propagado & r_carry);
        // New slice enters at the top; after N slices the shadow is complete.
        w_shadow_nxt  = (r_shadow >> SLICE) | (WIDTH'(w_res) << (WIDTH - SLICE));
    end

    // Signed overflow, valid on the last slice where r_a/r_b hold the MSB slice.
    always_comb begin
        w_bop_msb  = eh_subtracao(r_op) ? ~r_b[SLICE-1] : r_b[SLICE-1];
        w_overflow = eh_aritmetica(r_op)
                   && (r_a[SLICE-1] == w_bop_msb)
                   && (w_shadow_nxt[WIDTH-1] != r_a[SLICE-1]);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_estado_nxt = r_estado;
        case (r_estado)
            OCIOSO:  w_estado_nxt = w_aceita ? CALCULA : OCIOSO;
            CALCULA: w_estado_nxt = w_ultima ? PRONTO : CALCULA;
            PRONTO:  w_estado_nxt = w_aceita ? CALCULA : OCIOSO;
            default: w_estado_nxt = OCIOSO;
        endcase
    end

    // FSM outputs, decoded from the registered state.
    always_comb begin
        ocupado = 1'b0;
        pronto  = 1'b0;
        case (r_estado)
            CALCULA: ocupado = 1'b1;
            PRONTO:  pronto  = 1'b1;
            default: begin
                ocupado = 1'b0;
                pronto  = 1'b0;
            end
        endcase
    end

    // Operand latch, slice stepping and result/flag update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= {IDX_W{1'b0}};
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_op        <= OP_ADD;
            r_carry     <= 1'b0;
            r_shadow    <= {WIDTH{1'b0}};
            r_resultado <= {WIDTH{1'b0}};
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
            r_negativo  <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_aceita) begin
            r_idx   <= {IDX_W{1'b0}};
            r_a     <= A;
            r_b     <= B;
            r_op    <= seletor;
            r_carry <= carry_inicial(seletor, carry_in);
        end else if (r_estado == CALCULA) begin
            r_idx    <= r_idx + IDX_W'(1);
            r_a      <= r_a >> SLICE;
            r_b      <= r_b >> SLICE;
            r_carry  <= w_carry_grupo;
            r_shadow <= w_shadow_nxt;
            if (w_ultima) begin
                r_resultado <= w_shadow_nxt;
                r_carry_out <= w_cout;
                r_zero      <= (w_shadow_nxt == {WIDTH{1'b0}});
                r_negativo  <= w_shadow_nxt[WIDTH-1];
                r_overflow  <= w_overflow;
            end
        end
    end

    assign resultado = r_resultado;
    assign carry_out = r_carry_out;
    assign zero      = r_zero;
    assign negativo  = r_negativo;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ula_serial_fatias.sv
// Self-checking bench: an 8-bit (2 slices) and a 16-bit (4 slices) instance,
// each with an arithmetic reference model feeding a scoreboard queue that a
// negedge monitor drains when pronto is seen.
module tb_ula_serial_fatias;

    typedef struct {
        int          ciclo;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        inicio8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic [2:0]  sel8 = 3'd0;
    logic        oc8, pr8, c8, z8, n8, v8;
    logic [7:0]  res8;

    logic        inicio16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic [2:0]  sel16 = 3'd0;
    logic        oc16, pr16, c16, z16, n16, v16;
    logic [15:0] res16;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   ativo = 1'b0;
    exp_t fila [2][$];
    exp_t held [2];
    int   acc [2];
    int   nf [2];
    int   wd [2];

    ula_serial_fatias #(.WIDTH(8), .SLICE(4)) u_dut8 (
        .clk(clk), .rst(rst), .inicio(inicio8), .A(a8), .B(b8), .carry_in(cin8),
        .seletor(sel8), .ocupado(oc8), .pronto(pr8), .resultado(res8),
        .carry_out(c8), .zero(z8), .negativo(n8), .overflow(v8)
    );

    ula_serial_fatias #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst(rst), .inicio(inicio16), .A(a16), .B(b16), .carry_in(cin16),
        .seletor(sel16), .ocupado(oc16), .pronto(pr16), .resultado(res16),
        .carry_out(c16), .zero(z16), .negativo(n16), .overflow(v16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on w-bit values.
    function automatic exp_t modelo(input int w, input logic [2:0] op,
                                    input logic [15:0] a, input logic [15:0] b,
                                    input logic cin);
        exp_t e;
        longint m, ua, ub, bo, ci, s, r, sa, sb, half, ss;
        bit arit;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        arit = 1'b1;
        bo   = ub;
        ci   = 0;
        s    = 0;
        case (op)
            3'd0: ci = 0;
            3'd1: begin bo = ~ub & m; ci = 1; end
            3'd6: ci = cin ? 1 : 0;
            3'd7: begin bo = ~ub & m; ci = cin ? 1 : 0; end
            3'd2: begin arit = 1'b0; s = ua & ub; end
            3'd3: begin arit = 1'b0; s = ua | ub; end
            3'd4: begin arit = 1'b0; s = ua ^ ub; end
            default: begin arit = 1'b0; s = ~ua & m; end
        endcase
        e.c = 1'b0;
        e.v = 1'b0;
        if (arit) begin
            s   = ua + bo + ci;
            e.c = ((s >> w) & 1) != 0;
            sa  = (ua >= half) ? ua - 2 * half : ua;
            sb  = (bo >= half) ? bo - 2 * half : bo;
            ss  = sa + sb + ci;
            e.v = (ss >= half) || (ss < -half);
        end
        r       = s & m;
        e.res   = 16'(r);
        e.z     = (r == 0);
        e.n     = ((r >> (w - 1)) & 1) != 0;
        e.ciclo = 0;
        return e;
    endfunction

    task automatic limpa_modelo();
        for (int d = 0; d < 2; d++) begin
            fila[d].delete();
            acc[d]  = -100;
            held[d] = '{ciclo: 0, res: 16'h0000, c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};
        end
    endtask

    task automatic borda();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard check for one instance at a negedge.
    task automatic verifica(input int d, input logic [15:0] res, input logic pr,
                            input logic oc, input logic c, input logic z,
                            input logic n, input logic v);
        logic exp_oc;
        exp_oc = (cyc >= acc[d]) && (cyc <= acc[d] + nf[d] - 1);
        n_tests++;
        if (oc !== exp_oc) begin
            n_fail++;
            $display("FAIL ocupado d%0d cyc%0d: got %b want %b", d, cyc, oc, exp_oc);
        end
        if (fila[d].size() > 0 && fila[d][0].ciclo < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL pronto_missing d%0d cyc%0d: expected at cyc%0d", d, cyc, fila[d][0].ciclo);
            void'(fila[d].pop_front());
        end
        if (pr === 1'b1) begin
            n_tests++;
            if (fila[d].size() == 0) begin
                n_fail++;
                $display("FAIL pronto_unexpected d%0d cyc%0d: got pronto=1 want 0", d, cyc);
            end else begin
                if (fila[d][0].ciclo != cyc) begin
                    n_fail++;
                    $display("FAIL latency d%0d: got pronto at cyc%0d want cyc%0d", d, cyc, fila[d][0].ciclo);
                end
                held[d] = fila[d].pop_front();
            end
        end
        n_tests++;
        if (res !== held[d].res || c !== held[d].c || z !== held[d].z ||
            n !== held[d].n || v !== held[d].v) begin
            n_fail++;
            $display("FAIL result d%0d cyc%0d: got res=%h c%b z%b n%b v%b want res=%h c%b z%b n%b v%b",
                     d, cyc, res, c, z, n, v, held[d].res, held[d].c, held[d].z, held[d].n, held[d].v);
        end
    endtask

    // Monitor: decoupled from stimulus, runs every falling edge.
    always @(negedge clk) begin
        if (ativo) begin
            verifica(0, {8'h00, res8}, pr8, oc8, c8, z8, n8, v8);
            verifica(1, res16, pr16, oc16, c16, z16, n16, v16);
        end
    end

    // Drive one start request; the model decides whether it is accepted.
    task automatic emite(input int d, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        int   prev;
        exp_t e;
        @(negedge clk);
        if (d == 0) begin
            inicio8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sel8 = op; cin8 = cin;
        end else begin
            inicio16 = 1'b1; a16 = a; b16 = b; sel16 = op; cin16 = cin;
        end
        borda();
        prev = cyc - 1;
        if (!((prev >= acc[d]) && (prev <= acc[d] + nf[d] - 1)) && !rst) begin
            e       = modelo(wd[d], op, a, b, cin);
            e.ciclo = cyc + nf[d];
            fila[d].push_back(e);
            acc[d]  = cyc;
        end
        // Scramble inputs: latched values must not follow them.
        if (d == 0) begin
            inicio8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            sel8 = 3'($urandom); cin8 = 1'($urandom);
        end else begin
            inicio16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
            sel16 = 3'($urandom); cin16 = 1'($urandom);
        end
    endtask

    // Wait (on the bench's own cycle count) until the next request can land.
    task automatic espera(input int d, input int extra);
        while (cyc < acc[d] + nf[d]) borda();
        repeat (extra) borda();
    endtask

    task automatic reseta();
        @(negedge clk);
        rst = 1'b1;
        borda();
        limpa_modelo();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        nf[0] = 2; wd[0] = 8;
        nf[1] = 4; wd[1] = 16;
        limpa_modelo();
        rst = 1'b1;
        repeat (2) borda();
        ativo = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Directed 8-bit cases.
        emite(0, 3'd0, 16'h00F0, 16'h0020, 1'b0); espera(0, 1);
        emite(0, 3'd1, 16'h0005, 16'h0007, 1'b0); espera(0, 1);
        emite(0, 3'd0, 16'h007F, 16'h0001, 1'b0); espera(0, 1);
        emite(0, 3'd4, 16'h00AA, 16'h00AA, 1'b0); espera(0, 1);
        emite(0, 3'd5, 16'h000F, 16'h0055, 1'b0); espera(0, 1);
        // Request while busy is dropped; request in PRONTO cycle is taken.
        emite(0, 3'd0, 16'h0012, 16'h0034, 1'b0);
        emite(0, 3'd3, 16'h00FF, 16'h00FF, 1'b1);
        espera(0, 0);
        emite(0, 3'd2, 16'h003C, 16'h000F, 1'b0); espera(0, 2);
        // Reset in the middle of CALCULA, then a normal operation.
        emite(0, 3'd0, 16'h0011, 16'h0022, 1'b0);
        reseta();
        espera(0, 1);
        emite(0, 3'd0, 16'h0001, 16'h0002, 1'b0); espera(0, 1);

        // Randomized 8-bit traffic.
        for (int i = 0; i < 60; i++) begin
            emite(0, 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                emite(0, 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            espera(0, $urandom_range(0, 2));
        end

        // Directed 16-bit cases.
        emite(1, 3'd6, 16'hFFFF, 16'h0000, 1'b1); espera(1, 1);
        emite(1, 3'd7, 16'h1000, 16'h0001, 1'b1); espera(1, 1);
        emite(1, 3'd7, 16'h1000, 16'h0001, 1'b0); espera(1, 1);
        emite(1, 3'd1, 16'h8000, 16'h0001, 1'b0); espera(1, 1);

        // Randomized 16-bit traffic.
        for (int i = 0; i < 40; i++) begin
            emite(1, 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0)
                emite(1, 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            espera(1, $urandom_range(0, 2));
        end

        repeat (8) borda();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (fila[d].size() != 0) begin
                n_fail++;
                $display("FAIL drain d%0d: got %0d pending want 0", d, fila[d].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
